// File: rtl/aes_uart_ctrl.sv
// Byte-stream sequencer: 16 RX bytes -> AES block -> 16 TX ciphertext bytes.
// Optional RX inter-byte timeout enabled by defining AES_RX_TIMEOUT_EN.
module aes_uart_ctrl #(
    parameter int AES_LAT = 2,
    parameter int RX_TMO  = 1000000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [7:0]   rx_data,
    input  logic         rx_valid,
    output logic [127:0] aes_in,
    output logic         aes_en,
    input  logic [127:0] aes_out,
    input  logic         aes_chk,
    output logic [7:0]   tx_data,
    output logic         tx_valid,
    input  logic         tx_ready,
    output logic         busy,
    output logic         done,
    output logic         chk_ok,
    output logic         ovr,
    output logic         tmo
);

    localparam int LW = $clog2(AES_LAT + 1);

    typedef enum logic [1:0] {
        RECV,
        CRYPT,
        SEND
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [3:0]     cnt;
    logic [3:0]     txcnt;
    logic [LW-1:0]  lat;
    logic [127:0]   shift;
    logic           rx_last;
    logic           lat_last;
    logic           tx_fire;
    logic           tx_last;
    logic           tmo_hit;

    assign rx_last  = (state == RECV) && rx_valid && (cnt == 4'd15);
    assign lat_last = (state == CRYPT) && (lat == LW'(AES_LAT - 1));
    assign tx_fire  = (state == SEND) && tx_ready;
    assign tx_last  = tx_fire && (txcnt == 4'd15);
    assign tx_data  = shift[127:120];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RECV;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        aes_en    = 1'b0;
        tx_valid  = 1'b0;
        busy      = 1'b1;
        unique case (state)
            RECV: begin
                busy = 1'b0;
                if (rx_last) state_nxt = CRYPT;
            end
            CRYPT: begin
                aes_en = 1'b1;
                if (lat_last) state_nxt = SEND;
            end
            SEND: begin
                tx_valid = 1'b1;
                if (tx_last) state_nxt = RECV;
            end
            default: state_nxt = RECV;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            txcnt  <= '0;
            lat    <= '0;
            aes_in <= '0;
            shift  <= '0;
            chk_ok <= 1'b0;
            done   <= 1'b0;
            ovr    <= 1'b0;
        end else begin
            done <= tx_last;
            ovr  <= rx_valid && (state != RECV);
            // First received byte lands in the MSB lane.
            if ((state == RECV) && rx_valid) begin
                aes_in[{~cnt, 3'b000} +: 8] <= rx_data;
                cnt <= cnt + 4'd1;
            end else if (tmo_hit) begin
                cnt <= '0;
            end
            if (state == CRYPT) begin
                lat <= lat_last ? '0 : lat + LW'(1);
            end else begin
                lat <= '0;
            end
            if (lat_last) begin
                shift  <= aes_out;
                chk_ok <= aes_chk;
            end else if (tx_fire) begin
                shift <= shift << 8;
                txcnt <= txcnt + 4'd1;
            end
        end
    end

`ifdef AES_RX_TIMEOUT_EN
    localparam int IW = $clog2(RX_TMO + 1);

    logic [IW-1:0] idle;

    assign tmo_hit = (state == RECV) && (cnt != 4'd0) && !rx_valid &&
                     (idle == IW'(RX_TMO - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle <= '0;
            tmo  <= 1'b0;
        end else begin
            tmo <= tmo_hit;
            if ((state != RECV) || rx_valid || (cnt == 4'd0) || tmo_hit) begin
                idle <= '0;
            end else begin
                idle <= idle + IW'(1);
            end
        end
    end
`else
    logic unused_cfg;

    assign unused_cfg = (RX_TMO > 0);
    assign tmo_hit    = 1'b0;
    assign tmo        = 1'b0;
`endif

endmodule

// File: tb/tb_aes_uart_ctrl.sv
// Directed bench for aes_uart_ctrl with a table-driven AES stand-in.
// Covers FIPS-197 vector, backpressure, overrun, check fail, reset, timeout.
module tb_aes_uart_ctrl;

    localparam int LAT = 2;
    localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [7:0]   rx_data;
    logic         rx_valid;
    logic [127:0] aes_in;
    logic         aes_en;
    logic [127:0] aes_out;
    logic         aes_chk;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic         busy;
    logic         done;
    logic         chk_ok;
    logic         ovr;
    logic         tmo;
    logic         force_fail;

    int n_checks = 0;
    int n_fail = 0;
    int done_total = 0;
    int ovr_total = 0;
    int tmo_total = 0;

    always #5 clk = ~clk;

    // Only the known plaintext maps to the known ciphertext.
    assign aes_out = (aes_in == PT) ? CT : ~aes_in;
    assign aes_chk = ~force_fail;

    always @(negedge clk) begin
        if (done) done_total++;
        if (ovr) ovr_total++;
        if (tmo) tmo_total++;
    end

    aes_uart_ctrl #(.AES_LAT(LAT), .RX_TMO(20)) dut (
        .clk(clk), .rst_n(rst_n),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .aes_in(aes_in), .aes_en(aes_en),
        .aes_out(aes_out), .aes_chk(aes_chk),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .done(done), .chk_ok(chk_ok),
        .ovr(ovr), .tmo(tmo)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bytes(input logic [127:0] blk, input int first,
                              input int last);
        for (int i = first; i <= last; i++) begin
            rx_data  = blk[127-8*i -: 8];
            rx_valid = 1'b1;
            step();
        end
        rx_valid = 1'b0;
    endtask

    task automatic wait_tx(output int lat, output int en_cycles);
        lat = 1;
        en_cycles = 0;
        while (!tx_valid && lat < 100) begin
            if (aes_en) en_cycles++;
            step();
            lat++;
        end
    endtask

    task automatic collect(input int stall, input int maxb,
                           output logic [127:0] got, output int nacc,
                           output int unstable);
        int st;
        int budget;
        logic [7:0] held;
        got = '0;
        nacc = 0;
        unstable = 0;
        st = 0;
        budget = 0;
        held = '0;
        while (nacc < maxb && budget < 2000) begin
            if (tx_valid) begin
                if (st > 0 && tx_data !== held) unstable++;
                held = tx_data;
                if (st < stall) begin
                    tx_ready = 1'b0;
                    st++;
                end else begin
                    tx_ready = 1'b1;
                    got = {got[119:0], tx_data};
                    nacc++;
                    st = 0;
                end
            end else begin
                tx_ready = 1'b0;
            end
            step();
            budget++;
        end
        tx_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rx_data = '0;
        rx_valid = 1'b0;
        tx_ready = 1'b0;
        force_fail = 1'b0;
        repeat (3) step();
        n_checks++;
        if ({aes_en, tx_valid, busy, done, chk_ok, ovr, tmo} !== 7'd0) begin
            n_fail++;
            $display("FAIL reset_flags got %b want 0",
                     {aes_en, tx_valid, busy, done, chk_ok, ovr, tmo});
        end
        rst_n = 1'b1;
        step();
        n_checks++;
        if (aes_in !== 128'd0 || tx_data !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_data aes_in %h tx %h want 0", aes_in, tx_data);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy got %b want 0", busy);
        end
    endtask

    task automatic test_fips();
        int lat, en, nacc, uns, d0;
        logic [127:0] got;
        send_bytes(PT, 0, 15);
        n_checks++;
        if (aes_in !== PT || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL fips_aes_in got %h busy %b want %h busy 1",
                     aes_in, busy, PT);
        end
        wait_tx(lat, en);
        n_checks++;
        if (lat !== LAT + 1) begin
            n_fail++;
            $display("FAIL fips_latency got %0d want %0d", lat, LAT + 1);
        end
        n_checks++;
        if (en !== LAT) begin
            n_fail++;
            $display("FAIL fips_aes_en_cycles got %0d want %0d", en, LAT);
        end
        n_checks++;
        if (tx_data !== 8'h69) begin
            n_fail++;
            $display("FAIL fips_first_byte got %h want 69", tx_data);
        end
        d0 = done_total;
        collect(0, 16, got, nacc, uns);
        n_checks++;
        if (got !== CT || nacc !== 16) begin
            n_fail++;
            $display("FAIL fips_cipher got %h (%0d) want %h (16)", got, nacc, CT);
        end
        n_checks++;
        if (done !== 1'b1 || chk_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL fips_done done %b chk %b want 1 1", done, chk_ok);
        end
        step();
        n_checks++;
        if ({done, tx_valid, busy} !== 3'b000 || done_total - d0 !== 1) begin
            n_fail++;
            $display("FAIL fips_after done %b txv %b busy %b pulses %0d want 0 0 0 1",
                     done, tx_valid, busy, done_total - d0);
        end
    endtask

    task automatic test_backpressure();
        int lat, en, nacc, uns, d0;
        logic [127:0] got;
        d0 = done_total;
        send_bytes(PT, 0, 15);
        wait_tx(lat, en);
        collect(5, 16, got, nacc, uns);
        step();
        step();
        n_checks++;
        if (got !== CT || nacc !== 16) begin
            n_fail++;
            $display("FAIL bp_cipher got %h (%0d) want %h (16)", got, nacc, CT);
        end
        n_checks++;
        if (uns !== 0) begin
            n_fail++;
            $display("FAIL bp_stable changes %0d want 0", uns);
        end
        n_checks++;
        if (done_total - d0 !== 1 || tx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_done pulses %0d txv %b want 1 0",
                     done_total - d0, tx_valid);
        end
    endtask

    task automatic test_overrun();
        int lat, en, nacc, uns, o0;
        logic [127:0] got;
        o0 = ovr_total;
        send_bytes(PT, 0, 15);
        wait_tx(lat, en);
        rx_data = 8'haa;
        rx_valid = 1'b1;
        tx_ready = 1'b0;
        step();
        rx_valid = 1'b0;
        n_checks++;
        if (ovr !== 1'b1 || busy !== 1'b1 || tx_data !== 8'h69) begin
            n_fail++;
            $display("FAIL ovr_pulse ovr %b busy %b tx %h want 1 1 69",
                     ovr, busy, tx_data);
        end
        step();
        n_checks++;
        if (ovr !== 1'b0) begin
            n_fail++;
            $display("FAIL ovr_width got %b want 0", ovr);
        end
        collect(0, 16, got, nacc, uns);
        step();
        n_checks++;
        if (got !== CT || ovr_total - o0 !== 1) begin
            n_fail++;
            $display("FAIL ovr_stream got %h pulses %0d want %h 1",
                     got, ovr_total - o0, CT);
        end
        send_bytes(PT, 0, 15);
        n_checks++;
        if (aes_in !== PT) begin
            n_fail++;
            $display("FAIL ovr_next_block aes_in %h want %h", aes_in, PT);
        end
        wait_tx(lat, en);
        collect(0, 16, got, nacc, uns);
        step();
        n_checks++;
        if (got !== CT) begin
            n_fail++;
            $display("FAIL ovr_next_cipher got %h want %h", got, CT);
        end
    endtask

    task automatic test_reset_mid();
        int lat, en, nacc, uns;
        logic [127:0] got;
        send_bytes(PT, 0, 15);
        wait_tx(lat, en);
        collect(0, 7, got, nacc, uns);
        n_checks++;
        if (got[55:0] !== CT[127:72] || chk_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_partial got %h chk %b want %h 1",
                     got[55:0], chk_ok, CT[127:72]);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({aes_en, tx_valid, busy, done, chk_ok, ovr, tmo} !== 7'd0 ||
            tx_data !== 8'd0 || aes_in !== 128'd0) begin
            n_fail++;
            $display("FAIL rst_mid flags %b tx %h aes_in %h want 0",
                     {aes_en, tx_valid, busy, done, chk_ok, ovr, tmo},
                     tx_data, aes_in);
        end
        step();
        rst_n = 1'b1;
        step();
        send_bytes(PT, 0, 15);
        wait_tx(lat, en);
        n_checks++;
        if (lat !== LAT + 1) begin
            n_fail++;
            $display("FAIL rst_latency got %0d want %0d", lat, LAT + 1);
        end
        collect(0, 16, got, nacc, uns);
        n_checks++;
        if (got !== CT || done !== 1'b1 || chk_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_block got %h done %b chk %b want %h 1 1",
                     got, done, chk_ok, CT);
        end
        step();
    endtask

    task automatic test_chk_fail();
        int lat, en, nacc, uns;
        logic [127:0] got;
        force_fail = 1'b1;
        send_bytes(PT, 0, 15);
        wait_tx(lat, en);
        force_fail = 1'b0;
        collect(0, 16, got, nacc, uns);
        n_checks++;
        if (got !== CT) begin
            n_fail++;
            $display("FAIL chk_cipher got %h want %h", got, CT);
        end
        n_checks++;
        if (done !== 1'b1 || chk_ok !== 1'b0) begin
            n_fail++;
            $display("FAIL chk_flag done %b chk %b want 1 0", done, chk_ok);
        end
        step();
    endtask

    task automatic test_timeout();
        int lat, en, nacc, uns, t0;
        logic [127:0] got;
        t0 = tmo_total;
        send_bytes(PT, 0, 4);
        repeat (21) step();
`ifdef AES_RX_TIMEOUT_EN
        n_checks++;
        if (tmo_total - t0 !== 1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL tmo_pulse pulses %0d busy %b want 1 0",
                     tmo_total - t0, busy);
        end
        send_bytes(PT, 0, 15);
`else
        n_checks++;
        if (tmo_total - t0 !== 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL tmo_none pulses %0d busy %b want 0 0",
                     tmo_total - t0, busy);
        end
        send_bytes(PT, 5, 15);
`endif
        wait_tx(lat, en);
        collect(0, 16, got, nacc, uns);
        n_checks++;
        if (got !== CT || chk_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL tmo_block got %h chk %b want %h 1", got, chk_ok, CT);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_fips();
        test_backpressure();
        test_overrun();
        test_reset_mid();
        test_chk_fail();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
